// File: rtl/hex_tx_writer.sv
// Streams a snapshot of NWORDS 32-bit words to a byte-wide UART as uppercase ASCII hex lines.
// Optional macro HEX_TX_CRLF_EN terminates each word with CR LF instead of LF alone.
module hex_tx_writer #(
    parameter int unsigned NWORDS = 4
) (
    input  logic                   hz100,
    input  logic                   reset,
    input  logic                   start,
    input  logic [32*NWORDS-1:0]   words,
    input  logic                   txready,
    output logic [7:0]             txdata,
    output logic                   txclk,
    output logic                   busy,
    output logic                   done
);

`ifdef HEX_TX_CRLF_EN
    localparam int unsigned BPW = 10;
`else
    localparam int unsigned BPW = 9;
`endif
    localparam int unsigned BYTES = BPW * NWORDS;
    localparam int unsigned BI_W  = $clog2(10 * NWORDS);
    localparam int unsigned WI_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned CI_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        STROBE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [NWORDS-1:0][31:0]  snap_q, snap_d;
    logic [BI_W-1:0]          byte_idx_q, byte_idx_d;
    logic [WI_W-1:0]          word_idx_q, word_idx_d;
    logic [CI_W-1:0]          char_idx_q, char_idx_d;
    logic [7:0]               txdata_q, txdata_d;
    logic                     txclk_q, txclk_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic [7:0][3:0]          cur_word;
    logic [2:0]               nib_sel;
    logic [3:0]               nib;
    logic [7:0]               cur_byte;
    logic                     last_byte;

    // Current character: hex digit (MS nibble first) or line terminator.
    always_comb begin
        cur_word = snap_q[word_idx_q];
        nib_sel  = 3'(~char_idx_q[2:0]);
        nib      = cur_word[nib_sel];
        if (char_idx_q < CI_W'(8)) begin
            cur_byte = (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
        end
`ifdef HEX_TX_CRLF_EN
        else if (char_idx_q == CI_W'(8)) begin
            cur_byte = 8'h0D;
        end
`endif
        else begin
            cur_byte = 8'h0A;
        end
        last_byte = (byte_idx_q == BI_W'(BYTES - 1));
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        char_idx_d = char_idx_q;
        txdata_d   = txdata_q;
        txclk_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d     = words;
                    byte_idx_d = '0;
                    word_idx_d = '0;
                    char_idx_d = '0;
                    busy_d     = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (txready) begin
                    txdata_d = cur_byte;
                    txclk_d  = 1'b1;
                    state_d  = STROBE;
                end
            end
            STROBE: begin
                if (last_byte) begin
                    byte_idx_d = '0;
                    word_idx_d = '0;
                    char_idx_d = '0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end else begin
                    byte_idx_d = BI_W'(byte_idx_q + 1'b1);
                    if (char_idx_q == CI_W'(BPW - 1)) begin
                        char_idx_d = '0;
                        word_idx_d = WI_W'(word_idx_q + 1'b1);
                    end else begin
                        char_idx_d = CI_W'(char_idx_q + 1'b1);
                    end
                    state_d = SEND;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            char_idx_q <= '0;
            txdata_q   <= 8'h00;
            txclk_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            char_idx_q <= char_idx_d;
            txdata_q   <= txdata_d;
            txclk_q    <= txclk_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign txdata = txdata_q;
    assign txclk  = txclk_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_hex_tx_writer.sv
// Scoreboard bench for hex_tx_writer: expected ASCII bytes are queued at start, a monitor checks each strobe.
module tb_hex_tx_writer;

    localparam int NW = 4;
`ifdef HEX_TX_CRLF_EN
    localparam int BPW = 10;
`else
    localparam int BPW = 9;
`endif
    localparam int B = BPW * NW;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [32*NW-1:0] words = '0;
    logic             txready = 1'b1;
    logic [7:0]       txdata;
    logic             txclk;
    logic             busy;
    logic             done;

    hex_tx_writer #(.NWORDS(NW)) dut (
        .hz100   (clk),
        .reset   (reset),
        .start   (start),
        .words   (words),
        .txready (txready),
        .txdata  (txdata),
        .txclk   (txclk),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    logic [7:0] exp_q[$];
    int         stb_cyc[$];
    int         done_cyc[$];
    int         stb_cnt = 0;
    int         done_cnt = 0;
    bit         rand_rdy = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: each word as 8 uppercase hex chars, MS nibble first, then terminator.
    task automatic push_frame(input logic [32*NW-1:0] w);
        for (int i = 0; i < NW; i++) begin
            int unsigned wd;
            wd = w[32*i +: 32];
            for (int k = 7; k >= 0; k--) begin
                int unsigned n;
                n = (wd >> (4 * k)) & 32'hF;
                exp_q.push_back(n < 10 ? 8'(48 + n) : 8'(65 + n - 10));
            end
`ifdef HEX_TX_CRLF_EN
            exp_q.push_back(8'h0D);
`endif
            exp_q.push_back(8'h0A);
        end
    endtask

    // Monitor: byte ordering, spacing, txready causality, and hold-between-strobes.
    bit         armed = 1'b0;
    bit         prev_txclk = 1'b0;
    bit         prev_txready = 1'b0;
    logic [7:0] hold = 8'h00;
    always @(negedge clk) begin
        if (armed) begin
            if (txclk) begin
                stb_cnt++;
                stb_cyc.push_back(cyc);
                chk("strobe_spacing", 32'(prev_txclk), 32'd0);
                chk("strobe_needs_txready", 32'(prev_txready), 32'd1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe got=%0h want=no strobe (cycle %0d)", txdata, cyc);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("byte", 32'(txdata), 32'(e));
                    hold = e;
                end
            end else begin
                chk("txdata_hold", 32'(txdata), 32'(hold));
            end
            if (done) begin
                done_cnt++;
                done_cyc.push_back(cyc);
            end
        end
        if (reset) begin
            armed = 1'b1;
            hold  = 8'h00;
        end
        prev_txclk   = txclk;
        prev_txready = txready;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) txready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            step();
            n++;
        end
        chk("done_timeout", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic pulse_start(output int n);
        start = 1'b1;
        n = cyc;
        step();
        start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        logic [32*NW-1:0] dw;
        dw = {32'hDEADBEEF, 32'h9ABCDEF0, 32'h12345678, 32'h00000000};

        // Reset state
        #1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_txclk", 32'(txclk), 32'd0);
        chk("rst_txdata", 32'(txdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        step();
        reset = 1'b0;
        step();

        // Directed frame, txready held high: exact timing
        stb_cyc.delete();
        done_cyc.delete();
        words = dw;
        push_frame(dw);
        pulse_start(n);
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_done(1, 4 * B);
        chk("dir_strobes", 32'(stb_cyc.size()), 32'(B));
        chk("dir_first_strobe", 32'(stb_cyc[0]), 32'(n + 2));
        chk("dir_last_strobe", 32'(stb_cyc[stb_cyc.size()-1]), 32'(n + 2 * B));
        chk("dir_done_cycle", 32'(done_cyc[0]), 32'(n + 2 * B + 1));
        chk("dir_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("dir_busy_end", 32'(busy), 32'd0);

        // Random words with random txready
        rand_rdy = 1'b1;
        for (int f = 0; f < 3; f++) begin
            logic [32*NW-1:0] rw;
            rw = {$urandom, $urandom, $urandom, $urandom};
            words = rw;
            push_frame(rw);
            base = done_cnt;
            pulse_start(n);
            wait_done(base + 1, 20 * B);
            chk("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
        end
        rand_rdy = 1'b0;
        txready  = 1'b1;
        step();

        // Snapshot isolation and ignored mid-frame start
        words = dw;
        push_frame(dw);
        base = done_cnt;
        pulse_start(n);
        words = '1;
        repeat (20) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(base + 1, 4 * B);
        repeat (30) step();
        chk("snap_one_done", 32'(done_cnt), 32'(base + 1));
        chk("snap_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("snap_idle", 32'(busy), 32'd0);

        // Reset after the 10th strobe abandons the frame
        words = dw;
        push_frame(dw);
        base = stb_cnt;
        pulse_start(n);
        n = 0;
        while (stb_cnt < base + 10 && n < 4 * B) begin
            step();
            n++;
        end
        chk("rst10_reached", 32'(stb_cnt), 32'(base + 10));
        reset = 1'b1;
        exp_q.delete();
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst10_txclk", 32'(txclk), 32'd0);
        chk("rst10_txdata", 32'(txdata), 32'd0);
        chk("rst10_busy", 32'(busy), 32'd0);
        step();
        push_frame(dw);
        base = done_cnt;
        pulse_start(n);
        wait_done(base + 1, 4 * B);
        chk("rst10_refill_empty", 32'(exp_q.size()), 32'd0);

        // Reset coincident with start wins
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", 32'(busy), 32'd0);
        repeat (5) step();
        chk("rst_start_still_idle", 32'(busy), 32'd0);

        // Start held high: back-to-back frames
        stb_cyc.delete();
        done_cyc.delete();
        words = dw;
        push_frame(dw);
        push_frame(dw);
        push_frame(dw);
        base = done_cnt;
        start = 1'b1;
        n = cyc;
        wait_done(base + 2, 8 * B);
        start = 1'b0;
        wait_done(base + 3, 4 * B);
        repeat (5) step();
        chk("b2b_done_count", 32'(done_cyc.size()), 32'd3);
        if (done_cyc.size() == 3 && stb_cyc.size() == 3 * B) begin
            chk("b2b_done0", 32'(done_cyc[0]), 32'(n + 2 * B + 1));
            chk("b2b_period1", 32'(done_cyc[1] - done_cyc[0]), 32'(2 * B + 1));
            chk("b2b_period2", 32'(done_cyc[2] - done_cyc[1]), 32'(2 * B + 1));
            chk("b2b_first_after_done", 32'(stb_cyc[B]), 32'(done_cyc[0] + 2));
        end else begin
            chk("b2b_strobe_count", 32'(stb_cyc.size()), 32'(3 * B));
        end
        chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("b2b_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_tx_writer.md
HEX_TX_WRITER -- requirements
Module: hex_tx_writer

Interface
REQ-001 SHALL have parameter NWORDS, default 4, number of 32-bit result words per frame (legal 1..8).
REQ-002 SHALL have port hz100  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  frame request from solver, sampled only in IDLE.
REQ-005 SHALL have port words  input  32*NWORDS  result words; word k occupies bits [32k+31:32k].
REQ-006 SHALL have port txready  input  1  UART transmitter can take a byte.
REQ-007 SHALL have port txdata  output  8  ASCII byte to transmit, registered.
REQ-008 SHALL have port txclk  output  1  byte strobe, registered, high exactly one cycle per byte.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse on frame completion.

Function
REQ-011 SHALL implement states IDLE, SEND, STROBE; no other reachable states.
REQ-012 In IDLE with start=1: SHALL snapshot words into an internal register, clear byte index, set busy=1, go to SEND next cycle; later changes on words SHALL NOT affect the frame.
REQ-013 start while busy=1 SHALL be ignored (no queuing, no restart).
REQ-014 In SEND with txready=1: SHALL load txdata with the current byte, set txclk=1, go to STROBE; with txready=0 SHALL hold state, txclk=0, txdata unchanged.
REQ-015 In STROBE: SHALL set txclk=0; if current byte is last in frame, go to IDLE with busy=0 and done=1 for one cycle; else advance index and go to SEND.
REQ-016 Frame order SHALL be word 0 first; per word 8 hex characters, most-significant nibble first, then terminator per REQ-024.
REQ-017 Nibble encoding SHALL be 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (uppercase only).
REQ-018 With txready held 1 and start accepted at cycle N: txclk SHALL be high at cycles N+2, N+4, ..., N+2B; done high at N+2B+1; B = bytes per frame.
REQ-019 Minimum byte spacing SHALL be 2 cycles; txclk SHALL never be high in two consecutive cycles.
REQ-020 txdata SHALL hold the last transmitted byte until the next strobe.
REQ-021 start=1 in the cycle done=1 SHALL be accepted (back-to-back frames).
REQ-022 Byte index counter SHALL be sized for 10*NWORDS bytes with no wrap within a frame.

Reset
REQ-023 reset=1 at any clock edge, including mid-frame or coincident with start, SHALL force IDLE, txdata=0x00, txclk=0, busy=0, done=0, index=0; the partial frame is abandoned and not resumed.

Configuration
REQ-024 Macro HEX_TX_CRLF_EN: if defined, each word SHALL be terminated by 0x0D then 0x0A (B=10*NWORDS); if undefined, by 0x0A only (B=9*NWORDS).
REQ-025 Port list and timing rules SHALL be identical with and without HEX_TX_CRLF_EN.

Verification
REQ-026 Macro off, NWORDS=4, words={0x00000000,0x12345678,0x9ABCDEF0,0xDEADBEEF} (word0 first), txready=1, start pulse at N -> 36 strobes, bytes "00000000\n12345678\n9ABCDEF0\nDEADBEEF\n", last strobe N+72, done at N+73.
REQ-027 Macro on, same stimulus -> 40 strobes, each word followed by 0x0D,0x0A, done at N+81.
REQ-028 txready toggled pseudo-randomly (about 50 %) -> identical byte sequence, no strobe while txready=0 in preceding SEND cycle, no consecutive txclk highs.
REQ-029 words changed to 0xFFFFFFFF one cycle after start, plus second start pulse mid-frame -> original frame only, one done pulse.
REQ-030 reset asserted after 10th strobe for one cycle -> next cycle txclk=0, txdata=0x00, busy=0; subsequent start sends full frame from byte 0.
REQ-031 start held high continuously, txready=1 -> frames back-to-back, next frame's first strobe 2 cycles after done, done every 2B+1 cycles.
